// File: rtl/id_stage_reg.sv
// ============================================================================
// Module   : id_stage_reg
// Purpose  : IF->ID pipeline register with a 2-entry skid buffer. The main
//            opcode is decoded on the way in, so imm_src, uses_imm and illegal
//            are registered alongside each held entry.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_reg #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  // fetch side
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_instr,
  // redirect
  input  logic            flush,
  // decode side
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc4,
  output logic [31:0]     id_instr,
  output logic [2:0]      id_imm_src,
  output logic            id_uses_imm,
  output logic            id_illegal
);

  // Occupancy states: nothing held, main only, main plus skid.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  // Immediate format selects understood by the extender.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Main opcodes recognised by the decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // One held instruction together with everything decoded from it.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [31:0]     instr;
    logic [2:0]      imm_src;
    logic            uses_imm;
    logic            illegal;
  } entry_t;

  // Build a complete entry from a pc/instruction pair. pc4 is computed here
  // so the adder sits on the capture side, and wraps naturally at 2^XLEN.
  function automatic entry_t make_entry(input logic [XLEN-1:0] pc,
                                        input logic [31:0]     instr);
    entry_t e;
    e.pc       = pc;
    e.pc4      = pc + XLEN'(4);
    e.instr    = instr;
    e.imm_src  = IMM_I;
    e.uses_imm = 1'b0;
    e.illegal  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      // Compressed or malformed encodings are not supported.
      e.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR: begin
          e.imm_src  = IMM_I;
          e.uses_imm = 1'b1;
        end
        OP_STORE: begin
          e.imm_src  = IMM_S;
          e.uses_imm = 1'b1;
        end
        OP_BRANCH: begin
          e.imm_src  = IMM_B;
          e.uses_imm = 1'b1;
        end
        OP_JAL: begin
          e.imm_src  = IMM_J;
          e.uses_imm = 1'b1;
        end
        OP_LUI, OP_AUIPC: begin
          e.imm_src  = IMM_U;
          e.uses_imm = 1'b1;
        end
        OP_REG: begin
          e.imm_src  = IMM_I;
          e.uses_imm = 1'b0;
        end
        default: begin
          e.illegal = 1'b1;
        end
      endcase
    end
    return e;
  endfunction

  logic [1:0] state_q;
  logic [1:0] state_d;
  entry_t     main_q;
  entry_t     main_d;
  entry_t     skid_q;
  entry_t     skid_d;
  entry_t     in_entry;
  logic       xfer_in;
  logic       xfer_out;

  // Decode the offered instruction before it is captured.
  assign in_entry = make_entry(if_pc, if_instr);

  // Handshakes; both readies/valids come straight from the state flops.
  assign xfer_in  = if_valid & if_ready;
  assign xfer_out = id_valid & id_ready;

  // State register: occupancy of main/skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush empties the stage regardless of handshakes.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (xfer_in) state_d = S_ONE;
        end
        S_ONE: begin
          if (xfer_in && !xfer_out) begin
            state_d = S_TWO;
          end else if (!xfer_in && xfer_out) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (xfer_out) state_d = S_ONE;
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // Output logic: decoded purely from the state register.
  always_comb begin
    id_valid = (state_q != S_EMPTY);
    if_ready = (state_q != S_TWO);
  end

  // Entry movement: main takes the new input or the skid; skid only fills
  // when main is stalled. On flush main shows a NOP so decode sees a bubble.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = make_entry(main_q.pc, NOP_INSTR);
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (xfer_in) main_d = in_entry;
        end
        S_ONE: begin
          if (xfer_in && xfer_out) begin
            main_d = in_entry;
          end else if (xfer_in) begin
            skid_d = in_entry;
          end
        end
        S_TWO: begin
          if (xfer_out) main_d = skid_q;
        end
        default: begin
          main_d = main_q;
        end
      endcase
    end
  end

  // Entry registers: reset to a NOP at RESET_PC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= make_entry(RESET_PC, NOP_INSTR);
      skid_q <= make_entry(RESET_PC, NOP_INSTR);
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  // Decode-side outputs come directly from the main entry.
  assign id_pc       = main_q.pc;
  assign id_pc4      = main_q.pc4;
  assign id_instr    = main_q.instr;
  assign id_imm_src  = main_q.imm_src;
  assign id_uses_imm = main_q.uses_imm;
  assign id_illegal  = main_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_id_stage_reg.sv
// ============================================================================
// Module   : tb_id_stage_reg
// Purpose  : Self-checking bench for id_stage_reg. A FIFO-of-items model
//            (at most two held) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_pc = '0;
  logic [31:0] if_instr = '0;
  logic        flush = 1'b0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic [31:0] id_instr;
  logic [2:0]  id_imm_src;
  logic        id_uses_imm;
  logic        id_illegal;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  item_t q[$];
  bit    show_nop   = 1'b1;
  bit    show_reset = 1'b1;

  id_stage_reg #(
    .XLEN      (32),
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_pc4      (id_pc4),
    .id_instr    (id_instr),
    .id_imm_src  (id_imm_src),
    .id_uses_imm (id_uses_imm),
    .id_illegal  (id_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode straight from the opcode table.
  task automatic ref_decode(input logic [31:0] ins, output logic [2:0] imm,
                            output logic uses, output logic ill);
    imm = 3'd0; uses = 1'b0; ill = 1'b0;
    if (ins[1:0] != 2'b11) ill = 1'b1;
    else begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67: begin imm = 3'd0; uses = 1'b1; end
        7'h23:               begin imm = 3'd1; uses = 1'b1; end
        7'h63:               begin imm = 3'd2; uses = 1'b1; end
        7'h6f:               begin imm = 3'd3; uses = 1'b1; end
        7'h37, 7'h17:        begin imm = 3'd4; uses = 1'b1; end
        7'h33:               begin imm = 3'd0; uses = 1'b0; end
        default:             ill = 1'b1;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [2:0] imm;
    logic       uses;
    logic       ill;
    chk("if_ready", 32'(if_ready), 32'(q.size() < 2));
    chk("id_valid", 32'(id_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      ref_decode(q[0].instr, imm, uses, ill);
      chk("id_pc",       id_pc,             q[0].pc);
      chk("id_pc4",      id_pc4,            q[0].pc + 32'd4);
      chk("id_instr",    id_instr,          q[0].instr);
      chk("id_imm_src",  32'(id_imm_src),   32'(imm));
      chk("id_uses_imm", 32'(id_uses_imm),  32'(uses));
      chk("id_illegal",  32'(id_illegal),   32'(ill));
    end else if (show_nop) begin
      chk("nop_instr",    id_instr,            NOP);
      chk("nop_imm_src",  32'(id_imm_src),     32'd0);
      chk("nop_uses_imm", 32'(id_uses_imm),    32'd1);
      chk("nop_illegal",  32'(id_illegal),     32'd0);
      if (show_reset) begin
        chk("reset_pc",  id_pc,  32'h0000_0000);
        chk("reset_pc4", id_pc4, 32'h0000_0004);
      end
    end
  endtask

  // One clock: check current outputs at negedge, then advance the model with
  // the inputs that the rising edge samples.
  task automatic tick();
    bit    do_in;
    bit    do_out;
    bit    r_n;
    bit    fl;
    item_t it;
    @(negedge clk);
    check_outputs();
    r_n    = rst_n;
    fl     = flush;
    do_in  = if_valid && (q.size() < 2);
    do_out = id_ready && (q.size() > 0);
    it.pc    = if_pc;
    it.instr = if_instr;
    @(posedge clk);
    #1;
    if (!r_n) begin
      q.delete(); show_nop = 1'b1; show_reset = 1'b1;
    end else if (fl) begin
      q.delete(); show_nop = 1'b1; show_reset = 1'b0;
    end else begin
      if (do_out) void'(q.pop_front());
      if (do_in) begin
        q.push_back(it); show_nop = 1'b0; show_reset = 1'b0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    if_valid = v; if_pc = pc; if_instr = ins; id_ready = rdy; flush = fl;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h6f, 7'h37, 7'h17, 7'h33, 7'h7f};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  initial begin
    // 1: reset held while inputs toggle
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom));
      tick();
    end
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // 2: streaming with downstream always ready
    drive(1'b1, 32'h0, 32'h0041_2083, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h4, 32'h0011_2223, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h8, 32'hfe00_0ee3, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0,         1'b1, 1'b0); tick();
    tick();

    // 3: backpressure fills the skid, then drains in order
    drive(1'b1, 32'h100, 32'h0000_006f, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h104, 32'h1234_5037, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h108, 32'h0000_0013, 1'b0, 1'b0); tick();
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    tick();
    tick();

    // 4: flush while full with a concurrent offer
    drive(1'b1, 32'h200, 32'h0041_2083, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h204, 32'h0011_2223, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h208, 32'hfe00_0ee3, 1'b1, 1'b1); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h300, 32'h0000_006f, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    tick();

    // 5: illegal and R-type encodings
    drive(1'b1, 32'h400, 32'h0000_007f, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h404, 32'h0000_0000, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h408, 32'h0020_81b3, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    tick();

    // 6: pc wrap, then asynchronous reset while full
    drive(1'b1, 32'hFFFF_FFFC, 32'h1234_5037, 1'b1, 1'b0); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); tick();
    drive(1'b1, 32'h500, 32'h0041_2083, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h504, 32'h0011_2223, 1'b0, 1'b0); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_id_valid", 32'(id_valid), 32'd0);
    chk("async_if_ready", 32'(if_ready), 32'd1);
    chk("async_id_instr", id_instr,      NOP);
    chk("async_id_pc",    id_pc,         32'h0);
    q.delete(); show_nop = 1'b1; show_reset = 1'b1;
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
            rand_instr(), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
